// File: rtl/sm_trace_pkg.sv
// -----------------------------------------------------------------------------
// sm_trace_pkg
//   Shared definitions for the sm_trace execution-trace capture buffer:
//   capture FSM state encodings, trace entry width and the entry layout.
//   No ports.
// -----------------------------------------------------------------------------
package sm_trace_pkg;

    // Encodings are fixed so on-board tooling can decode the state directly.
    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_POST    = 2'd2,
        TR_DONE    = 2'd3
    } tr_state_e;

    localparam int TR_ENTRY_W = 64;

    // One captured instruction: pc in the upper word, instr in the lower word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } tr_entry_t;

endpackage : sm_trace_pkg

// File: rtl/sm_trace_ram.sv
// -----------------------------------------------------------------------------
// sm_trace_ram
//   DEPTH x 64-bit storage for the trace buffer. One synchronous write port,
//   one asynchronous (combinational) read port. Contents are never reset.
// Ports
//   clk      in   system clock
//   we_i     in   write enable
//   waddr_i  in   AW   write address
//   wdata_i  in   64   write data (tr_entry_t)
//   raddr_i  in   AW   read address
//   rdata_o  out  64   read data at raddr_i
// -----------------------------------------------------------------------------
module sm_trace_ram
    import sm_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  tr_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output tr_entry_t       rdata_o
);

    logic [TR_ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : sm_trace_ram

// File: rtl/sm_trace_buf.sv
// -----------------------------------------------------------------------------
// sm_trace_buf
//   Execution-trace capture buffer downstream of sm_cpu. Stores {pc, instr}
//   samples in a circular buffer, stops a fixed number of entries after a PC
//   trigger, and drains through a show-ahead valid/ready read port.
// Configuration
//   SM_TRACE_NOP_FILTER_EN : when defined, cap_instr==0 samples are neither
//                            stored, counted toward the post window, nor able
//                            to fire the trigger.
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   arm        in   pulse: flush buffer and start capture
//   cap_valid  in   cap_pc/cap_instr valid this cycle
//   cap_pc     in   32 word-index PC
//   cap_instr  in   32 instruction word
//   trig_en    in   enable PC trigger
//   trig_pc    in   32 trigger PC
//   rd_ready   in   consumer accepts head entry
//   rd_valid   out  buffer non-empty
//   rd_pc      out  32 head entry pc (0 when empty)
//   rd_instr   out  32 head entry instr (0 when empty)
//   count      out  AW+1 entries held, 0..DEPTH
//   overflow   out  sticky: oldest entry overwritten since last arm
//   done       out  post-trigger window complete
// -----------------------------------------------------------------------------
module sm_trace_buf
    import sm_trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int POST_CNT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          cap_valid,
    input  logic [31:0]   cap_pc,
    input  logic [31:0]   cap_instr,
    input  logic          trig_en,
    input  logic [31:0]   trig_pc,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_instr,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          done
);

    localparam int          PW       = (POST_CNT < 2) ? 1 : $clog2(POST_CNT + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] POST_LD = PW'(POST_CNT);

    tr_state_e      state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  post_q, post_d;

    logic           is_nop;
    logic           push;
    logic           pop;
    logic           full;
    logic           trig_hit;
    tr_entry_t      wdata;
    tr_entry_t      rdata;

`ifdef SM_TRACE_NOP_FILTER_EN
    assign is_nop = (cap_instr == 32'h0);
`else
    assign is_nop = 1'b0;
`endif

    // arm wins over everything in its cycle: captures and pops are dropped.
    assign push     = !arm && cap_valid && !is_nop
                      && ((state_q == TR_CAPTURE) || (state_q == TR_POST));
    assign pop      = !arm && rd_valid && rd_ready;
    assign full     = (count_q == FULL_CNT);
    assign trig_hit = trig_en && (cap_pc == trig_pc);
    assign wdata    = '{pc: cap_pc, instr: cap_instr};

    sm_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TR_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            post_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            post_q     <= post_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        post_d     = post_q;

        if (arm) begin
            state_d    = TR_CAPTURE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            post_d     = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            // Full with push and no pop overwrites the oldest entry: the read
            // pointer steps past it and count stays pinned at DEPTH.
            if (push && pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else if (push && full) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                overflow_d = 1'b1;
            end else if (push) begin
                count_d = count_q + 1'b1;
            end else if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end

            case (state_q)
                TR_CAPTURE: begin
                    if (push && trig_hit) begin
                        if (POST_CNT == 0) begin
                            state_d = TR_DONE;
                        end else begin
                            state_d = TR_POST;
                            post_d  = POST_LD;
                        end
                    end
                end
                TR_POST: begin
                    if (push) begin
                        post_d = post_q - 1'b1;
                        if (post_q == PW'(1)) begin
                            state_d = TR_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_pc    = rd_valid ? rdata.pc    : 32'h0;
    assign rd_instr = rd_valid ? rdata.instr : 32'h0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = (state_q == TR_DONE);

endmodule : sm_trace_buf
